aes_host_if: RTL and testbench
==============================

// Module: aes_host_if
// PURPOSE
//  Word-serial host interface for the AES-128 encryption core. Collects key and plaintext as
//  eight 32-bit words over a valid/ready input stream and drives the core's 128-bit key/plaintext.
//  Holds the core in reset while loading, releases it to run, and captures ciphertext on core
//  finish. Returns the ciphertext as four 32-bit words on a valid/ready output stream.
// PARAMETERS
//  WORD_W    32   host word width; TEXT_W/WORD_W must be 4
//  TEXT_W    128  key/plaintext/ciphertext width
//  TIMEOUT   31   max RUN cycles without core finish before abort (5-bit counter)
// PORTS
//  clk_i              in   1    clock, all logic on rising edge
//  rst_i              in   1    synchronous reset, active-high
//  in_data_i          in   32   load word
//  in_valid_i         in   1    load word valid
//  in_ready_o         out  1    block accepts load word
//  out_data_o         out  32   ciphertext word
//  out_valid_o        out  1    ciphertext word valid
//  out_ready_i        in   1    host accepts ciphertext word
//  busy_o             out  1    operation in progress (partial load, RUN or UNLOAD)
//  timeout_o          out  1    sticky: last run aborted on TIMEOUT
//  core_rst_no        out  1    core reset, active-low; 1 only in RUN
//  core_key_o         out  128  key to core
//  core_plaintext_o   out  128  plaintext to core
//  core_ciphertext_i  in   128  core ciphertext (final addroundkey output)
//  core_finish_i      in   1    core done flag
// BEHAVIOUR
//  - Reset: state=LOAD, load_cnt=0, out_cnt=0, run_cnt=0, timeout_o=0, key/pt/out buffers=0.
//    Outputs after reset: in_ready_o=1, out_valid_o=0, busy_o=0, core_rst_no=0.
//    All outputs decode registered state, so there are no combinational in->out paths.
//  - LOAD: in_ready_o=1, core_rst_no=0. Words are accepted on in_valid_i&in_ready_o. Word order:
//    k[127:96], k[95:64], k[63:32], k[31:0], then p[127:96] .. p[31:0]. load_cnt is 3 bits.
//    The first accepted word clears timeout_o. Accepting the 8th word (load_cnt==7) moves to RUN
//    next cycle with load_cnt wrapped to 0. Gaps in in_valid_i are allowed without limit.
//  - core_key_o and core_plaintext_o are written only in LOAD and are stable throughout RUN.
//  - RUN: in_ready_o=0, core_rst_no=1, run_cnt increments each cycle.
//    First cycle with core_finish_i=1: capture core_ciphertext_i into out_buf, set out_cnt=0,
//    go to UNLOAD. That cycle's value is captured; later finish levels are ignored.
//    If run_cnt==TIMEOUT and core_finish_i=0: set timeout_o=1, go to LOAD, run_cnt=0.
//    On abort, out_buf is not written and no output is produced.
//    Finish has priority over timeout in the same cycle.
//  - UNLOAD: core_rst_no=0, out_valid_o=1, out_data_o=out_buf word out_cnt, MSW first.
//    out_data_o holds stable while out_valid_o&!out_ready_i. out_cnt advances on handshake.
//    The 4th handshake returns to LOAD next cycle with in_ready_o=1. There is no in/out overlap.
//  - busy_o = (state!=LOAD) | (load_cnt!=0).
//  - Latency: last load word at edge T -> core_rst_no=1 from T+1. Capture at finish edge F ->
//    out_valid_o=1 from F+1. Nominal core run is 11 cycles.
//  - rst_i at any point (mid-load, RUN, UNLOAD) discards all partial data. Reset values apply
//    the next cycle; core_rst_no=0 from that cycle.
// TESTING
//  1. FIPS-197 App.B: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, pt 3243f6a8_885a308d_313198a2_e0370734
//     -> out words 3925841d,02dc09fb,dc118597,196a0b32; busy_o=0 after the last one.
//  2. FIPS-197 C.1: key 00010203..0e0f, pt 00112233..eeff, random in_valid_i gaps
//     -> 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
//  3. Backpressure: out_ready_i=0 for 5 cycles per word in test 1 -> out_data_o stable,
//     exactly 4 handshakes, correct order.
//  4. Stub core with finish never high -> timeout_o=1 after 32 RUN cycles, state LOAD,
//     no out_valid_o; next load clears timeout_o and test 1 passes.
//  5. rst_i after 5 loaded words -> in_ready_o=1, busy_o=0; a fresh full load of test 2
//     gives correct output, no stale words.
//  6. rst_i during UNLOAD after 2 words -> out_valid_o=0 next cycle, core_rst_no=0;
//     a new load runs cleanly.

Source files
------------

// File: rtl/aes_host_if.sv
// Word-serial host wrapper for the AES-128 core. It loads the key and plaintext as 32-bit words
// and runs the core under a cycle watchdog. The ciphertext is streamed back out MSW first.
module aes_host_if #(
  parameter int WORD_W  = 32,
  parameter int TEXT_W  = 128,
  parameter int TIMEOUT = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              core_rst_no,
  output logic [TEXT_W-1:0] core_key_o,
  output logic [TEXT_W-1:0] core_plaintext_o,
  input  logic [TEXT_W-1:0] core_ciphertext_i,
  input  logic              core_finish_i
);

  localparam int N_WORDS = TEXT_W / WORD_W;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_UNLOAD = 2'd2;

  localparam logic [2:0] LAST_LOAD = 3'(2 * N_WORDS - 1);
  localparam logic [1:0] LAST_OUT  = 2'(N_WORDS - 1);
  localparam logic [4:0] RUN_LIMIT = 5'(TIMEOUT);

  logic [1:0] state_reg, state_next;
  logic [2:0] load_cnt_reg, load_cnt_next;
  logic [1:0] out_cnt_reg, out_cnt_next;
  logic [4:0] run_cnt_reg, run_cnt_next;
  logic       timeout_reg, timeout_next;

  logic              in_fire;
  logic              out_fire;
  logic              capture;
  logic [TEXT_W-1:0] out_buf;
  logic [1:0]        out_sel;

  assign in_fire  = (state_reg == ST_LOAD) && in_valid_i;
  assign out_fire = (state_reg == ST_UNLOAD) && out_ready_i;
  // Only the first finish cycle can capture, because RUN is left on that same edge.
  assign capture  = (state_reg == ST_RUN) && core_finish_i;

  always_comb begin
    state_next    = state_reg;
    load_cnt_next = load_cnt_reg;
    out_cnt_next  = out_cnt_reg;
    run_cnt_next  = run_cnt_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      ST_LOAD: begin
        if (in_fire) begin
          load_cnt_next = load_cnt_reg + 3'd1;
          if (load_cnt_reg == 3'd0) begin
            timeout_next = 1'b0;
          end
          if (load_cnt_reg == LAST_LOAD) begin
            state_next   = ST_RUN;
            run_cnt_next = 5'd0;
          end
        end
      end

      ST_RUN: begin
        // Finish wins over the watchdog when both land on the same cycle.
        if (core_finish_i) begin
          state_next   = ST_UNLOAD;
          out_cnt_next = 2'd0;
          run_cnt_next = 5'd0;
        end else if (run_cnt_reg == RUN_LIMIT) begin
          state_next   = ST_LOAD;
          timeout_next = 1'b1;
          run_cnt_next = 5'd0;
        end else begin
          run_cnt_next = run_cnt_reg + 5'd1;
        end
      end

      ST_UNLOAD: begin
        if (out_fire) begin
          out_cnt_next = out_cnt_reg + 2'd1;
          if (out_cnt_reg == LAST_OUT) begin
            state_next = ST_LOAD;
          end
        end
      end

      default: begin
        state_next    = ST_LOAD;
        load_cnt_next = 3'd0;
        out_cnt_next  = 2'd0;
        run_cnt_next  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_LOAD;
      load_cnt_reg <= 3'd0;
      out_cnt_reg  <= 2'd0;
      run_cnt_reg  <= 5'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      out_cnt_reg  <= out_cnt_next;
      run_cnt_reg  <= run_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Word gi is bits [gi*WORD_W +: WORD_W]. The host sends the MSW first, so word gi of the key
  // arrives at load slot N_WORDS-1-gi.
  genvar gi;
  for (gi = 0; gi < N_WORDS; gi++) begin : g_word
    localparam logic [2:0] KEY_SLOT = 3'(N_WORDS - 1 - gi);
    localparam logic [2:0] PT_SLOT  = 3'(2 * N_WORDS - 1 - gi);

    logic [WORD_W-1:0] key_word_reg;
    logic [WORD_W-1:0] pt_word_reg;
    logic [WORD_W-1:0] ct_word_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        key_word_reg <= '0;
        pt_word_reg  <= '0;
        ct_word_reg  <= '0;
      end else begin
        if (in_fire && (load_cnt_reg == KEY_SLOT)) begin
          key_word_reg <= in_data_i;
        end
        if (in_fire && (load_cnt_reg == PT_SLOT)) begin
          pt_word_reg <= in_data_i;
        end
        if (capture) begin
          ct_word_reg <= core_ciphertext_i[gi*WORD_W +: WORD_W];
        end
      end
    end

    assign core_key_o[gi*WORD_W +: WORD_W]       = key_word_reg;
    assign core_plaintext_o[gi*WORD_W +: WORD_W] = pt_word_reg;
    assign out_buf[gi*WORD_W +: WORD_W]          = ct_word_reg;
  end

  assign out_sel     = LAST_OUT - out_cnt_reg;
  assign out_data_o  = out_buf[out_sel*WORD_W +: WORD_W];
  assign in_ready_o  = (state_reg == ST_LOAD);
  assign out_valid_o = (state_reg == ST_UNLOAD);
  assign core_rst_no = (state_reg == ST_RUN);
  assign busy_o      = (state_reg != ST_LOAD) || (load_cnt_reg != 3'd0);
  assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_aes_host_if.sv
// Bench for aes_host_if. A stub core with a programmable finish latency drives the DUT.
// The stub returns the FIPS-197 ciphertexts for the known vectors and a fixed mix otherwise.
module tb_aes_host_if;

  localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] C1 = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         timeout;
  logic         core_rst_n;
  logic [127:0] core_key;
  logic [127:0] core_pt;
  logic [127:0] core_ct;
  logic         core_finish;

  logic [7:0]   stub_lat = 8'd10;
  logic [7:0]   stub_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_host_if #(.WORD_W(32), .TEXT_W(128), .TIMEOUT(31)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_data_i         (in_data),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .out_data_o        (out_data),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .busy_o            (busy),
    .timeout_o         (timeout),
    .core_rst_no       (core_rst_n),
    .core_key_o        (core_key),
    .core_plaintext_o  (core_pt),
    .core_ciphertext_i (core_ct),
    .core_finish_i     (core_finish)
  );

  // Reference cipher: the real AES results for the two FIPS vectors, and a fixed mix otherwise.
  function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return k ^ {p[31:0], p[127:32]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // Stub core: it counts cycles out of reset and raises finish at count == stub_lat (255 = never).
  // The ciphertext drifts on later finish cycles, so a late capture shows up as a wrong word.
  always_ff @(posedge clk) begin
    if (!core_rst_n) stub_cnt <= 8'd0;
    else if (stub_cnt != 8'hff) stub_cnt <= stub_cnt + 8'd1;
  end
  assign core_finish = core_rst_n && (stub_lat != 8'hff) && (stub_cnt >= stub_lat);
  assign core_ct = core_finish ? (model_ct(core_key, core_pt) ^ {120'd0, stub_cnt - stub_lat})
                               : ~model_ct(core_key, core_pt);

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    int           lat;
    int           bp;
    bit           gaps;
    bit           exp_to;
    logic [127:0] exp_ct;
  } vec_t;

  vec_t vecs[16];

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_core_rst_n", core_rst_n, 1'b0);
    check_bit("rst_timeout", timeout, 1'b0);
  endtask

  task automatic do_load(input logic [127:0] key, input logic [127:0] pt, input bit gaps,
                         input int n_words);
    logic [31:0] word;
    for (int w = 0; w < n_words; w++) begin
      word = (w < 4) ? key[127 - 32*w -: 32] : pt[127 - 32*(w-4) -: 32];
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      check_bit("load_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = word;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      if (w == 0) check_bit("load_clears_timeout", timeout, 1'b0);
      check_bit("load_busy", busy, 1'b1);
    end
  endtask

  task automatic do_run(input logic [127:0] key, input logic [127:0] pt, input int lat,
                        input bit exp_to);
    int cycles = 0;
    check_bit("run_core_rst_n", core_rst_n, 1'b1);
    check_bit("run_in_ready", in_ready, 1'b0);
    check_vec("run_key", core_key, key);
    check_vec("run_pt", core_pt, pt);
    while (core_rst_n && cycles < 100) begin
      cycles++;
      if (core_key !== key || core_pt !== pt) check_vec("run_key_stable", core_key, key);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (exp_to) begin
      check_int("timeout_run_cycles", cycles, 32);
      check_bit("timeout_flag", timeout, 1'b1);
      check_bit("timeout_no_out", out_valid, 1'b0);
      check_bit("timeout_in_ready", in_ready, 1'b1);
      check_bit("timeout_busy", busy, 1'b0);
    end else begin
      check_int("run_cycles", cycles, lat + 1);
      check_bit("unload_start_valid", out_valid, 1'b1);
      check_bit("unload_no_timeout", timeout, 1'b0);
    end
  endtask

  task automatic do_unload(input logic [127:0] ct, input int bp, input int n_words);
    logic [31:0] word;
    for (int w = 0; w < n_words; w++) begin
      word = ct[127 - 32*w -: 32];
      check_bit("unload_valid", out_valid, 1'b1);
      check_vec("unload_word", {96'd0, out_data}, {96'd0, word});
      for (int b = 0; b < bp; b++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check_bit("bp_valid_held", out_valid, 1'b1);
        check_vec("bp_word_stable", {96'd0, out_data}, {96'd0, word});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (n_words == 4) begin
      check_bit("done_out_valid", out_valid, 1'b0);
      check_bit("done_in_ready", in_ready, 1'b1);
      check_bit("done_busy", busy, 1'b0);
      check_bit("done_core_rst_n", core_rst_n, 1'b0);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int bad_before = bad;
    stub_lat = (v.lat > 254) ? 8'hff : 8'(v.lat);
    do_load(v.key, v.pt, v.gaps, 8);
    do_run(v.key, v.pt, v.lat, v.exp_to);
    if (!v.exp_to) do_unload(v.exp_ct, v.bp, 4);
    $display("op %0d: key=%h pt=%h lat=%0d bp=%0d timeout=%0b errors=%0d",
             idx, v.key, v.pt, v.lat, v.bp, v.exp_to, bad - bad_before);
  endtask

  initial begin
    vecs[0] = '{key: K1, pt: P1, lat: 10, bp: 0, gaps: 1'b0, exp_to: 1'b0, exp_ct: C1};
    vecs[1] = '{key: K2, pt: P2, lat: 10, bp: 0, gaps: 1'b1, exp_to: 1'b0, exp_ct: C2};
    vecs[2] = '{key: K1, pt: P1, lat: 10, bp: 5, gaps: 1'b0, exp_to: 1'b0, exp_ct: C1};
    vecs[3] = '{key: K1, pt: P1, lat: 255, bp: 0, gaps: 1'b0, exp_to: 1'b1, exp_ct: C1};
    vecs[4] = '{key: K1, pt: P1, lat: 10, bp: 1, gaps: 1'b0, exp_to: 1'b0, exp_ct: C1};
    vecs[5] = '{key: K2, pt: P1, lat: 0, bp: 0, gaps: 1'b0, exp_to: 1'b0, exp_ct: model_ct(K2, P1)};
    vecs[6] = '{key: K1, pt: P2, lat: 31, bp: 0, gaps: 1'b0, exp_to: 1'b0, exp_ct: model_ct(K1, P2)};
    vecs[7] = '{key: K2, pt: P2, lat: 32, bp: 0, gaps: 1'b0, exp_to: 1'b1, exp_ct: C2};
    for (int i = 8; i < 16; i++) begin
      vecs[i].key    = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt     = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].lat    = $urandom_range(0, 40);
      vecs[i].bp     = $urandom_range(0, 3);
      vecs[i].gaps   = 1'($urandom_range(0, 1));
      vecs[i].exp_to = (vecs[i].lat > 31);
      vecs[i].exp_ct = model_ct(vecs[i].key, vecs[i].pt);
    end

    repeat (3) @(negedge clk);
    pulse_reset();
    check_vec("rst_core_key", core_key, 128'd0);
    check_vec("rst_core_pt", core_pt, 128'd0);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset after five loaded words, then a clean full load.
    stub_lat = 8'd10;
    do_load(K1, P1, 1'b0, 5);
    pulse_reset();
    check_vec("rst_discard_key", core_key, 128'd0);
    run_vec(100, vecs[1]);

    // Reset in the middle of RUN.
    do_load(K2, P2, 1'b0, 8);
    repeat (3) @(negedge clk);
    pulse_reset();
    run_vec(101, vecs[0]);

    // Reset during UNLOAD after two words.
    stub_lat = 8'd10;
    do_load(K1, P1, 1'b0, 8);
    do_run(K1, P1, 10, 1'b0);
    do_unload(C1, 0, 2);
    pulse_reset();
    run_vec(102, vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
